axis_byte_packer: RTL and testbench

AXI-Stream width converter that packs a byte stream (8-bit) into BYTES-wide words, placing the first accepted byte in lane 0.
Sits directly upstream of the n-byte axi_stream_if consumer, whose monitor pops expected bytes in lane order 0..n-1.
Supports early word termination via in_tlast, with lane qualification on out_tkeep.
Sustains 1 byte/clk with no bubbles while out_tready=1.

---
 rtl/axis_byte_packer_pkg.sv | 20 ++
 rtl/axis_byte_packer_if.sv | 29 ++
 rtl/axis_byte_packer_out_reg.sv | 46 ++++
 rtl/axis_byte_packer.sv | 73 +++++++
 tb/tb_axis_byte_packer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_byte_packer_pkg.sv
// Shared constants and helpers for the byte-to-word AXI-Stream packer.
// DEF_BYTES is the default output word width; modules may override it.
package axis_pack_pkg;

    localparam int BYTE_W    = 8;
    localparam int DEF_BYTES = 4;

    typedef logic [$clog2(DEF_BYTES)-1:0] lane_cnt_t;

    // Mask with the low 'lanes' bits set, e.g. keep_mask(2) = 4'b0011.
    function automatic logic [DEF_BYTES-1:0] keep_mask(input int lanes);
        logic [DEF_BYTES-1:0] m;
        m = '0;
        for (int k = 0; k < DEF_BYTES; k++) begin
            if (k < lanes) m[k] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/axis_byte_packer_if.sv
// Byte-in / word-out stream bundle around the packer.
// Handshake: a beat transfers on a rising clk edge where valid & ready are both 1;
// a source holds valid and its payload stable until that edge, and ready may
// depend combinationally on the same-cycle payload (in_tready looks at in_tlast).
interface axis_byte_packer_if #(
    parameter int BYTES = 4
);
    logic [7:0]         in_tdata;
    logic               in_tvalid;
    logic               in_tlast;
    logic               in_tready;
    logic [8*BYTES-1:0] out_tdata;
    logic [BYTES-1:0]   out_tkeep;
    logic               out_tlast;
    logic               out_tvalid;
    logic               out_tready;

    // Packer side.
    modport slave (
        input  in_tdata, in_tvalid, in_tlast, out_tready,
        output in_tready, out_tdata, out_tkeep, out_tlast, out_tvalid
    );

    // Byte source / word sink side.
    modport master (
        output in_tdata, in_tvalid, in_tlast, out_tready,
        input  in_tready, out_tdata, out_tkeep, out_tlast, out_tvalid
    );
endinterface

// File: rtl/axis_byte_packer_out_reg.sv
// Single-entry AXI-Stream holding register for a packed word.
// The loader only asserts i_load when the entry is empty or draining this cycle.
module axis_out_reg
    import axis_pack_pkg::*;
#(
    parameter int BYTES = DEF_BYTES
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_load,
    input  logic [BYTE_W*BYTES-1:0] i_data,
    input  logic [BYTES-1:0]        i_keep,
    input  logic                    i_last,
    input  logic                    i_ready,
    output logic                    o_valid,
    output logic [BYTE_W*BYTES-1:0] o_data,
    output logic [BYTES-1:0]        o_keep,
    output logic                    o_last
);
    logic                    r_valid;
    logic [BYTE_W*BYTES-1:0] r_data;
    logic [BYTES-1:0]        r_keep;
    logic                    r_last;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_keep  <= i_keep;
            r_last  <= i_last;
        end else if (i_ready) begin
            // Payload is left as-is after a drain; only valid drops.
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_keep  = r_keep;
    assign o_last  = r_last;
endmodule

// File: rtl/axis_byte_packer.sv
// Packs an 8-bit AXI-Stream into BYTES-wide words, first byte in lane 0,
// closing a word early on in_tlast with out_tkeep marking the filled lanes.
module axis_byte_packer
    import axis_pack_pkg::*;
#(
    parameter int BYTES = DEF_BYTES
) (
    input  logic               clk,
    input  logic               reset_n,
    axis_byte_packer_if.slave  bus
);
    localparam int CNT_W = $clog2(BYTES);
    localparam int W     = BYTE_W * BYTES;

    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_acc;
    logic [BYTES-1:0] r_acc_keep;

    logic             w_out_valid;
    logic             w_last_lane;
    logic             w_in_tready;
    logic             w_accept;
    logic             w_complete;
    logic [W-1:0]     w_word;
    logic [BYTES-1:0] w_keep;

    assign w_last_lane = (r_cnt == CNT_W'(BYTES-1)) | bus.in_tlast;
    // Only a word-completing byte needs the output register free.
    assign w_in_tready = reset_n & (~w_out_valid | bus.out_tready | ~w_last_lane);
    assign w_accept    = bus.in_tvalid & w_in_tready;
    assign w_complete  = w_accept & w_last_lane;

    // Accumulator merged with the incoming byte; lanes above r_cnt stay zero.
    always_comb begin
        w_word = r_acc;
        w_keep = r_acc_keep;
        for (int k = 0; k < BYTES; k++) begin
            if (CNT_W'(k) == r_cnt) begin
                w_word[k*BYTE_W +: BYTE_W] = bus.in_tdata;
                w_keep[k]                  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || w_complete) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_acc_keep <= '0;
        end else if (w_accept) begin
            r_cnt      <= r_cnt + CNT_W'(1);
            r_acc      <= w_word;
            r_acc_keep <= w_keep;
        end
    end

    axis_out_reg #(.BYTES(BYTES)) u_out_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_complete),
        .i_data  (w_word),
        .i_keep  (w_keep),
        .i_last  (bus.in_tlast),
        .i_ready (bus.out_tready),
        .o_valid (w_out_valid),
        .o_data  (bus.out_tdata),
        .o_keep  (bus.out_tkeep),
        .o_last  (bus.out_tlast)
    );

    assign bus.in_tready  = w_in_tready;
    assign bus.out_tvalid = w_out_valid;
endmodule

// File: tb/tb_axis_byte_packer.sv
// Directed and randomized checks of axis_byte_packer with BYTES=4.
module tb_axis_byte_packer;
    import axis_pack_pkg::*;

    localparam int BYTES = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    axis_byte_packer_if #(.BYTES(BYTES)) bus ();

    axis_byte_packer #(.BYTES(BYTES)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0]  exp_q[$];
    int          cnt_wr = 0;
    int          cnt_rd = 0;
    bit          sb_en = 1'b0;
    int          stall_seen = 0;
    bit          rand_done = 1'b0;

    bit          mon_hold = 1'b0;
    logic [36:0] mon_prev = '0;
    logic [8:0]  mon_e;
    int          mon_top;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte and hold it until accepted (bounded).
    task automatic send_byte(input logic [7:0] d, input logic last);
        bit done;
        done = 1'b0;
        bus.in_tdata  = d;
        bus.in_tlast  = last;
        bus.in_tvalid = 1'b1;
        for (int t = 0; t < 500 && !done; t++) begin
            @(negedge clk);
            if (bus.in_tready) begin
                done = 1'b1;
                if (sb_en) begin
                    exp_q.push_back({last, d});
                    cnt_wr++;
                end
            end else begin
                stall_seen++;
            end
            tick();
        end
        bus.in_tvalid = 1'b0;
        bus.in_tlast  = 1'b0;
        check("send_accepted", 64'(done), 64'd1);
    endtask

    task automatic check_word(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
        @(negedge clk);
        check({tag, "_valid"}, 64'(bus.out_tvalid), 64'd1);
        check({tag, "_data"},  64'(bus.out_tdata),  64'(d));
        check({tag, "_keep"},  64'(bus.out_tkeep),  64'(k));
        check({tag, "_last"},  64'(bus.out_tlast),  64'(l));
    endtask

    // Scoreboard: pops one expected byte per kept lane of each emitted word.
    always @(negedge clk) begin
        if (sb_en) begin
            if (mon_hold) begin
                check("hold_valid", 64'(bus.out_tvalid), 64'd1);
                check("hold_word", 64'({bus.out_tlast, bus.out_tkeep, bus.out_tdata}), 64'(mon_prev));
            end
            if (bus.out_tvalid && bus.out_tready) begin
                mon_top = $countones(bus.out_tkeep) - 1;
                check("sb_keep_shape", 64'(bus.out_tkeep), 64'(keep_mask(mon_top + 1)));
                check("sb_full_unless_last", 64'(bus.out_tlast || bus.out_tkeep == 4'hF), 64'd1);
                for (int k = 0; k < BYTES; k++) begin
                    if (bus.out_tkeep[k]) begin
                        check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
                        if (exp_q.size() != 0) begin
                            mon_e = exp_q.pop_front();
                            cnt_rd++;
                            check("sb_byte", 64'(bus.out_tdata[k*8 +: 8]), 64'(mon_e[7:0]));
                            check("sb_lane_last", 64'(mon_e[8]),
                                  64'((k == mon_top) ? bus.out_tlast : 1'b0));
                        end
                    end
                end
            end
            mon_hold = bus.out_tvalid && !bus.out_tready;
            mon_prev = {bus.out_tlast, bus.out_tkeep, bus.out_tdata};
        end else begin
            mon_hold = 1'b0;
        end
    end

    initial begin
        bus.in_tdata   = 8'h00;
        bus.in_tvalid  = 1'b0;
        bus.in_tlast   = 1'b0;
        bus.out_tready = 1'b1;

        // Reset: in_tready forced low even with a byte offered.
        reset_n = 1'b0;
        bus.in_tvalid = 1'b1;
        bus.in_tdata  = 8'h5A;
        repeat (3) tick();
        @(negedge clk);
        check("rst_in_tready",  64'(bus.in_tready),  64'd0);
        check("rst_out_tvalid", 64'(bus.out_tvalid), 64'd0);
        check("rst_out_tdata",  64'(bus.out_tdata),  64'd0);
        check("rst_out_tkeep",  64'(bus.out_tkeep),  64'd0);
        check("rst_out_tlast",  64'(bus.out_tlast),  64'd0);
        tick();
        bus.in_tvalid = 1'b0;
        reset_n = 1'b1;
        tick();

        // Full word; valid appears the cycle after the 4th byte.
        send_byte(8'h41, 1'b0);
        send_byte(8'h42, 1'b0);
        send_byte(8'h43, 1'b0);
        @(negedge clk);
        check("full_pre_valid", 64'(bus.out_tvalid), 64'd0);
        tick();
        send_byte(8'h44, 1'b0);
        check_word("full", 32'h44434241, 4'hF, 1'b0);
        tick();
        @(negedge clk);
        check("full_drained", 64'(bus.out_tvalid), 64'd0);
        tick();

        // Early termination, 1-lane word, and tlast on the top lane.
        send_byte(8'h41, 1'b0);
        send_byte(8'h42, 1'b1);
        check_word("short2", 32'h00004241, 4'h3, 1'b1);
        tick();
        send_byte(8'h77, 1'b1);
        check_word("short1", 32'h00000077, 4'h1, 1'b1);
        tick();
        send_byte(8'hA0, 1'b0);
        send_byte(8'hA1, 1'b0);
        send_byte(8'hA2, 1'b0);
        send_byte(8'hA3, 1'b1);
        check_word("full_last", 32'hA3A2A1A0, 4'hF, 1'b1);
        tick();

        // Backpressure: held word plus 3 non-completing bytes, 4th stalls.
        bus.out_tready = 1'b0;
        send_byte(8'h41, 1'b0);
        send_byte(8'h42, 1'b0);
        send_byte(8'h43, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h51, 1'b0);
        send_byte(8'h52, 1'b0);
        send_byte(8'h53, 1'b0);
        bus.in_tdata  = 8'h54;
        bus.in_tvalid = 1'b1;
        @(negedge clk);
        check("stall_in_tready", 64'(bus.in_tready), 64'd0);
        check("stall_data", 64'(bus.out_tdata), 64'h44434241);
        tick();
        @(negedge clk);
        check("stall_in_tready2", 64'(bus.in_tready), 64'd0);
        check("stall_valid2", 64'(bus.out_tvalid), 64'd1);
        check("stall_data2", 64'(bus.out_tdata), 64'h44434241);
        bus.out_tready = 1'b1;
        #1;
        check("release_in_tready", 64'(bus.in_tready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_tvalid = 1'b0;
        check_word("reload", 32'h54535251, 4'hF, 1'b0);
        tick();
        send_byte(8'h55, 1'b0);
        send_byte(8'h56, 1'b0);
        send_byte(8'h57, 1'b0);
        send_byte(8'h58, 1'b0);
        check_word("after_stall", 32'h58575655, 4'hF, 1'b0);
        tick();

        // Streaming 1024 bytes: words exactly BYTES cycles apart, never stalled.
        stall_seen = 0;
        begin
            int words;
            int bad_gap;
            int cyc;
            int last_cyc;
            logic [31:0] exp_w;
            words = 0;
            bad_gap = 0;
            fork
                begin
                    for (int i = 0; i < 1024; i++) send_byte(8'(i), 1'b0);
                end
                begin
                    cyc = 0;
                    last_cyc = 0;
                    for (int t = 0; t < 3000 && words < 256; t++) begin
                        @(negedge clk);
                        cyc++;
                        if (bus.out_tvalid) begin
                            for (int k = 0; k < 4; k++) exp_w[k*8 +: 8] = 8'(4*words + k);
                            check("stream_word", 64'(bus.out_tdata), 64'(exp_w));
                            if (words > 0 && cyc - last_cyc != BYTES) bad_gap++;
                            last_cyc = cyc;
                            words++;
                        end
                    end
                end
            join
            check("stream_words", 64'(words), 64'd256);
            check("stream_gaps", 64'(bad_gap), 64'd0);
            check("stream_stalls", 64'(stall_seen), 64'd0);
        end
        tick();

        // Reset mid-word drops the partial bytes.
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        reset_n = 1'b0;
        bus.in_tdata  = 8'h99;
        bus.in_tvalid = 1'b1;
        @(negedge clk);
        check("mid_rst_in_tready", 64'(bus.in_tready), 64'd0);
        tick();
        @(negedge clk);
        check("mid_rst_valid", 64'(bus.out_tvalid), 64'd0);
        check("mid_rst_data",  64'(bus.out_tdata),  64'd0);
        check("mid_rst_keep",  64'(bus.out_tkeep),  64'd0);
        tick();
        bus.in_tvalid = 1'b0;
        reset_n = 1'b1;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        check_word("post_rst", 32'h44332211, 4'hF, 1'b0);
        tick();

        // Random valid/ready/tlast against the lane-order scoreboard.
        sb_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    while ($urandom_range(0, 1) == 0) tick();
                    send_byte(8'($urandom_range(0, 255)), (i == 9999) || ($urandom_range(0, 7) == 0));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    bus.out_tready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        bus.out_tready = 1'b1;
        for (int t = 0; t < 50 && cnt_rd != cnt_wr; t++) tick();
        repeat (2) tick();
        check("rand_cnt_rd_wr", 64'(cnt_rd), 64'(cnt_wr));
        check("rand_cnt_wr", 64'(cnt_wr), 64'd10000);
        check("rand_q_empty", 64'(exp_q.size()), 64'd0);
        sb_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
